// File: rtl/mac_seq.sv
// Dot-product sequencer: clears the MAC, streams len operand pairs from two
// synchronous-read memories into it, then holds the accumulator on a valid/ready port.
module mac_seq #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   len,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data_a,
   input  logic [7:0]    rd_data_b,
   output logic [7:0]    mac_in1,
   output logic [7:0]    mac_in2,
   output logic          mac_clr,
   input  logic [25:0]   mac_acc,
   output logic [25:0]   result,
   output logic          result_vld,
   input  logic          result_rdy,
   output logic          busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      FETCH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] index_q, index_d;
   logic          dv_q, dv_d;
   logic          last_fetch;

   // Widen index by one bit so it compares against len-1 even when len == 2^AW.
   assign last_fetch = ({1'b0, index_q} == (len_q - (AW+1)'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         index_q <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         index_q <= index_d;
         dv_q    <= dv_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      index_d    = index_q;
      rd_en      = 1'b0;
      rd_addr    = '0;
      mac_clr    = 1'b0;
      result     = '0;
      result_vld = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = len;
               index_d = '0;
               state_d = CLR;
            end
         end
         CLR: begin
            mac_clr = 1'b1;
            state_d = (len_q != '0) ? FETCH : DRAIN;
         end
         FETCH: begin
            rd_en   = 1'b1;
            rd_addr = index_q;
            index_d = index_q + AW'(1);
            if (last_fetch) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            // Operands are forced to zero here, so mac_acc cannot move while we wait.
            result_vld = 1'b1;
            result     = mac_acc;
            if (result_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      dv_d = rd_en;
   end

   assign mac_in1 = dv_q ? rd_data_a : 8'd0;
   assign mac_in2 = dv_q ? rd_data_b : 8'd0;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: behavioural MAC and memories, directed commands,
// expected results queued at issue and checked by an independent monitor.
module tb_mac_seq;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   len_i;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data_a, rd_data_b;
   logic [7:0]    mac_in1, mac_in2;
   logic          mac_clr;
   logic [25:0]   mac_acc;
   logic [25:0]   result;
   logic          result_vld;
   logic          result_rdy;
   logic          busy;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic signed [25:0] acc_m;

   typedef struct {
      longint res;
      int     cyc;
   } exp_t;
   exp_t sbq[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int first_cyc = 0;
   int rd_cnt = 0;
   int clr_cnt = 0;
   int exp_addr = 0;
   logic vld_prev = 1'b0;

   mac_seq #(.AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len_i),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .mac_in1    (mac_in1),
      .mac_in2    (mac_in2),
      .mac_clr    (mac_clr),
      .mac_acc    (mac_acc),
      .result     (result),
      .result_vld (result_vld),
      .result_rdy (result_rdy),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem_a[rd_addr];
         rd_data_b <= mem_b[rd_addr];
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc_m <= '0;
      else if (mac_clr) acc_m <= '0;
      else              acc_m <= acc_m + $signed(mac_in1) * $signed(mac_in2);
   end
   assign mac_acc = acc_m;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: read-side bookkeeping and scoreboard pop on each result handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         vld_prev = 1'b0;
      end else begin
         if (mac_clr) begin
            clr_cnt++;
            exp_addr = 0;
         end
         if (rd_en) begin
            chk("rd_addr", rd_addr, exp_addr);
            exp_addr++;
            rd_cnt++;
         end
         if (result_vld && !vld_prev) first_cyc = cyc;
         if (result_vld && result_rdy) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got %0d, expected no result", $signed(result));
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("result", $signed(result), e.res);
               chk("vld_latency", first_cyc, e.cyc);
            end
         end
         vld_prev = result_vld;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input int n, input longint exp_res, input int hold);
      int  s;
      bit  ok;
      rd_cnt  = 0;
      clr_cnt = 0;
      start   = 1'b1;
      len_i   = n[AW:0];
      step();
      start = 1'b0;
      s = cyc;
      sbq.push_back('{exp_res, s + n + 2});
      chk("busy_rise", busy, 1);
      if (hold > 0) begin
         ok = 0;
         for (int k = 0; k < n + 20; k++) begin
            @(negedge clk);
            if (result_vld) begin ok = 1; break; end
         end
         if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL vld_timeout: got no result_vld, expected one within %0d cycles", n + 20);
         end
         for (int i = 0; i < hold; i++) begin
            step();
            start = (i == 3);
            @(negedge clk);
            chk("bp_vld", result_vld, 1);
            chk("bp_result", $signed(result), exp_res);
            chk("bp_in1", mac_in1, 0);
            chk("bp_in2", mac_in2, 0);
         end
         step();
         start = 1'b0;
         result_rdy = 1'b1;
      end
      ok = 0;
      for (int k = 0; k < n + 40; k++) begin
         @(negedge clk);
         if (result_vld && result_rdy) begin ok = 1; break; end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL hs_timeout: got no handshake, expected one within %0d cycles", n + 40);
      end
      step();
      chk("busy_fall", busy, 0);
      chk("vld_fall", result_vld, 0);
      chk("rd_count", rd_cnt, n);
      chk("clr_count", clr_cnt, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      len_i = '0;
      result_rdy = 1'b1;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'd0;
         mem_b[i] = 8'd0;
      end
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_vld", result_vld, 0);
      chk("rst_result", result, 0);
      step();
      rst_n = 1'b1;
      step();

      // Reset mid-FETCH with len=5.
      for (int i = 0; i < 5; i++) begin
         mem_a[i] = 8'(i + 1);
         mem_b[i] = 8'(i + 3);
      end
      start = 1'b1;
      len_i = 9'd5;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("pre_rst_rd_en", rd_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", rd_en, 0);
      chk("mid_rst_rd_addr", rd_addr, 0);
      chk("mid_rst_in1", mac_in1, 0);
      chk("mid_rst_in2", mac_in2, 0);
      chk("mid_rst_clr", mac_clr, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_vld", result_vld, 0);
      chk("mid_rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rd_en", rd_en, 0);
      chk("post_rst_in1", mac_in1, 0);
      chk("post_rst_in2", mac_in2, 0);

      // Basic: {1,2,3,4}.{5,6,7,8} = 70
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 8'(i + 1);
         mem_b[i] = 8'(i + 5);
      end
      run_cmd(4, 70, 0);
      step();

      // Empty vector.
      run_cmd(0, 0, 0);
      step();

      // Signed extremes over the full 256-entry memory.
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h80;
         mem_b[i] = 8'h80;
      end
      run_cmd(256, 4194304, 0);
      step();
      for (int i = 0; i < 256; i++) mem_b[i] = 8'h7F;
      run_cmd(256, -4161536, 0);
      step();

      // Backpressure: {-1,2,-3}.{4,4,4} = -8, rdy low for 10 cycles.
      mem_a[0] = 8'hFF; mem_a[1] = 8'h02; mem_a[2] = 8'hFD;
      mem_b[0] = 8'h04; mem_b[1] = 8'h04; mem_b[2] = 8'h04;
      result_rdy = 1'b0;
      run_cmd(3, -8, 10);

      // Back-to-back: {3,-4}.{10,2} = 22, then {-7}.{9} = -63.
      mem_a[0] = 8'h03; mem_a[1] = 8'hFC;
      mem_b[0] = 8'h0A; mem_b[1] = 8'h02;
      run_cmd(2, 22, 0);
      mem_a[0] = 8'hF9;
      mem_b[0] = 8'h09;
      run_cmd(1, -63, 0);
      step();

      chk("sb_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
